if_fetch_unit: RTL and testbench

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

---
 rtl/if_fetch_unit.sv | 106 ++++++++++
 tb/tb_if_fetch_unit.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: keeps at most one instruction-memory request in flight and feeds the
// IF/ID register, with stall hold, redirect flush and a kill flag for responses already in flight.
module if_fetch_unit #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PC_W   = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pause,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              valid_o,
  output logic [DATA_W-1:0] inst_o,
  output logic [PC_W-1:0]   pc_o,
  output logic [DATA_W-1:0] pc4_o,
  output logic [7:0]        discard_cnt
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StFull} state_e;

  state_e          state_q;
  logic [PC_W-1:0] pc_q;
  logic            kill_q;

  logic [PC_W-1:0] redirect_tgt;
  logic [PC_W-1:0] pc_seq;
  logic [PC_W-1:0] pc_o_plus4;
  logic [7:0]      discard_inc;

  assign redirect_tgt = {redirect_pc[PC_W-1:2], 2'b00};
  assign pc_seq       = pc_q + PC_W'(4);
  assign pc_o_plus4   = pc_o + PC_W'(4);
  assign pc4_o        = DATA_W'(pc_o_plus4);
  assign discard_inc  = (discard_cnt == 8'hFF) ? discard_cnt : discard_cnt + 8'd1;

  assign imem_req  = (state_q == StReq);
  assign imem_addr = pc_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      pc_q        <= '0;
      kill_q      <= 1'b0;
      valid_o     <= 1'b0;
      inst_o      <= '0;
      pc_o        <= '0;
      discard_cnt <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          state_q <= StReq;
          if (redirect) pc_q <= redirect_tgt;
        end

        StReq: begin
          if (redirect) pc_q <= redirect_tgt;
          if (imem_gnt) begin
            state_q <= StWait;
            // The accepted request already targets the stale path.
            kill_q  <= redirect;
          end
        end

        StWait: begin
          if (imem_rvalid) begin
            if (kill_q || redirect) begin
              kill_q      <= 1'b0;
              discard_cnt <= discard_inc;
              state_q     <= StReq;
              if (redirect) pc_q <= redirect_tgt;
            end else begin
              inst_o  <= imem_rdata;
              pc_o    <= pc_q;
              valid_o <= 1'b1;
              state_q <= StFull;
            end
          end else if (redirect) begin
            pc_q   <= redirect_tgt;
            kill_q <= 1'b1;
          end
        end

        StFull: begin
          // Redirect wins over both stall and consumption.
          if (redirect) begin
            pc_q    <= redirect_tgt;
            valid_o <= 1'b0;
            state_q <= StReq;
          end else if (!pause) begin
            pc_q    <= pc_seq;
            valid_o <= 1'b0;
            state_q <= StReq;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: behavioural memory, PC-stream reference model and a
// scoreboard queue popped by an output monitor; directed scenarios followed by random traffic.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pause = 1'b0;
  logic        redirect = 1'b0;
  logic [8:0]  redirect_pc = '0;
  logic        imem_req;
  logic [8:0]  imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        valid_o;
  logic [31:0] inst_o;
  logic [8:0]  pc_o;
  logic [31:0] pc4_o;
  logic [7:0]  discard_cnt;

  if_fetch_unit #(.DATA_W(32), .PC_W(9)) dut (
    .clk         (clk),
    .rst         (rst),
    .pause       (pause),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .valid_o     (valid_o),
    .inst_o      (inst_o),
    .pc_o        (pc_o),
    .pc4_o       (pc4_o),
    .discard_cnt (discard_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [8:0] a);
    if (a == 9'd0) return 32'h00500093;
    return (32'(a) * 32'h9E3779B9) ^ 32'h13570000;
  endfunction

  // Behavioural instruction memory: one request at a time, response after lat cycles.
  int         gnt_pct = 100;
  int         lat_min = 1;
  int         lat_max = 1;
  bit         mem_busy = 1'b0;
  int         mem_cnt = 0;
  logic [8:0] mem_addr = '0;

  always @(posedge clk) begin
    if (imem_rvalid) mem_busy = 1'b0;
    if (imem_req === 1'b1 && imem_gnt) begin
      mem_busy = 1'b1;
      mem_addr = imem_addr;
      mem_cnt  = int'($urandom_range(lat_max, lat_min));
    end
  end

  always @(negedge clk) begin
    if (mem_busy && mem_cnt > 0) mem_cnt--;
    imem_rvalid = mem_busy && (mem_cnt == 0);
    imem_rdata  = imem_rvalid ? mem_word(mem_addr) : $urandom;
    imem_gnt    = !mem_busy && (int'($urandom_range(99)) < gnt_pct);
  end

  // Reference model: the fetch stream is sequential from the last redirect target; a response
  // whose request saw a redirect before it returned is dropped and counted.
  typedef struct packed {
    logic [8:0]  pc;
    logic [31:0] inst;
  } exp_t;

  exp_t       exp_q[$];
  logic [8:0] exp_fetch = '0;
  logic [8:0] live_pc = '0;
  logic [8:0] pend_addr = '0;
  bit         pend = 1'b0;
  bit         pend_dead = 1'b0;
  bit         live = 1'b0;
  bit         in_rst = 1'b0;
  int         exp_disc = 0;

  always @(posedge clk) begin : model
    logic [8:0] tgt;
    exp_t       e;
    if (!rst) begin
      in_rst    = 1'b1;
      exp_fetch = '0;
      pend      = 1'b0;
      pend_dead = 1'b0;
      live      = 1'b0;
      exp_disc  = 0;
      exp_q.delete();
    end else begin
      in_rst = 1'b0;
      tgt    = redirect_pc & 9'h1FC;
      if (live && (redirect || !pause)) begin
        if (!redirect) exp_fetch = live_pc + 9'd4;
        live = 1'b0;
      end
      if (imem_req && imem_gnt) begin
        chk("req_addr", 32'(imem_addr), 32'(exp_fetch));
        pend      = 1'b1;
        pend_addr = imem_addr;
        pend_dead = redirect;
      end else if (pend && imem_rvalid) begin
        if (pend_dead || redirect) begin
          if (exp_disc < 255) exp_disc++;
        end else begin
          e.pc   = pend_addr;
          e.inst = mem_word(pend_addr);
          exp_q.push_back(e);
          live    = 1'b1;
          live_pc = pend_addr;
        end
        pend = 1'b0;
      end else if (pend && redirect) begin
        pend_dead = 1'b1;
      end
      if (redirect) exp_fetch = tgt;
    end
  end

  // Output monitor.
  bit   prev_valid = 1'b0;
  exp_t cur = '0;

  always @(negedge clk) begin
    if (in_rst) begin
      chk("rst_valid", 32'(valid_o), 32'd0);
      chk("rst_inst", inst_o, 32'd0);
      chk("rst_pc", 32'(pc_o), 32'd0);
      chk("rst_discard", 32'(discard_cnt), 32'd0);
      chk("rst_req", 32'(imem_req), 32'd0);
      prev_valid = 1'b0;
    end else begin
      chk("valid", 32'(valid_o), 32'(live));
      chk("discard_cnt", 32'(discard_cnt), 32'(exp_disc));
      if (imem_req) chk("addr_align", 32'(imem_addr[1:0]), 32'd0);
      if (valid_o) chk("req_in_full", 32'(imem_req), 32'd0);
      if (valid_o && !prev_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pop_empty: instruction pc=0x%0h presented, none expected", pc_o);
        end else begin
          cur = exp_q.pop_front();
          chk("inst", inst_o, cur.inst);
          chk("pc", 32'(pc_o), 32'(cur.pc));
          chk("pc4", pc4_o, 32'(9'(cur.pc + 9'd4)));
        end
      end else if (valid_o) begin
        chk("hold_inst", inst_o, cur.inst);
        chk("hold_pc", 32'(pc_o), 32'(cur.pc));
      end
      prev_valid = valid_o;
    end
  end

  task automatic wait_ev(input bit on_valid, input bit any_addr, input logic [8:0] a,
                         input string nm);
    int n = 0;
    bit hit = 1'b0;
    while (!hit && n < 200) begin
      @(negedge clk);
      n++;
      hit = on_valid ? (valid_o && (any_addr || pc_o == a))
                     : (imem_req && (any_addr || imem_addr == a));
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL %s: event not seen within %0d cycles (addr 0x%0h)", nm, n, a);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Minimum latency out of reset.
    repeat (3) @(negedge clk);
    chk("first_valid", 32'(valid_o), 32'd1);
    chk("first_inst", inst_o, 32'h00500093);
    chk("first_pc", 32'(pc_o), 32'd0);
    chk("first_pc4", pc4_o, 32'd4);
    wait_ev(1'b0, 1'b1, 9'd0, "req_after_first");
    chk("next_addr4", 32'(imem_addr), 32'd4);

    // Stall in FULL.
    wait_ev(1'b1, 1'b0, 9'd8, "full_pc8");
    pause = 1'b1;
    repeat (5) @(negedge clk);
    chk("pause_valid", 32'(valid_o), 32'd1);
    chk("pause_pc", 32'(pc_o), 32'd8);
    chk("pause_no_req", 32'(imem_req), 32'd0);
    pause = 1'b0;
    wait_ev(1'b0, 1'b1, 9'd0, "req_after_pause");
    chk("next_addr12", 32'(imem_addr), 32'd12);

    // Redirect while waiting on addr 16.
    lat_min = 3;
    lat_max = 3;
    wait_ev(1'b0, 1'b0, 9'd16, "req_addr16");
    @(negedge clk);
    redirect    = 1'b1;
    redirect_pc = 9'h042;
    @(negedge clk);
    redirect = 1'b0;
    wait_ev(1'b0, 1'b1, 9'd0, "req_after_kill");
    chk("kill_addr", 32'(imem_addr), 32'h40);
    chk("kill_discard", 32'(discard_cnt), 32'd1);

    // PC wrap at the top of the address space, unaligned redirect target.
    lat_min = 1;
    lat_max = 1;
    wait_ev(1'b1, 1'b1, 9'd0, "valid_any");
    redirect    = 1'b1;
    redirect_pc = 9'h1FE;
    @(negedge clk);
    redirect = 1'b0;
    wait_ev(1'b1, 1'b0, 9'h1FC, "full_1fc");
    chk("wrap_pc4", pc4_o, 32'd0);
    wait_ev(1'b0, 1'b1, 9'd0, "req_after_wrap");
    chk("wrap_addr", 32'(imem_addr), 32'd0);

    // Redirect and pause together in FULL.
    wait_ev(1'b1, 1'b0, 9'd0, "full_wrap0");
    pause       = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 9'h080;
    @(negedge clk);
    pause    = 1'b0;
    redirect = 1'b0;
    chk("rp_valid", 32'(valid_o), 32'd0);
    chk("rp_req", 32'(imem_req), 32'd1);
    chk("rp_addr", 32'(imem_addr), 32'h80);

    // Reset while a response is in flight; it arrives after release.
    lat_min = 3;
    lat_max = 3;
    wait_ev(1'b0, 1'b1, 9'd0, "req_before_rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wait_ev(1'b0, 1'b1, 9'd0, "req_after_rst");
    chk("post_rst_addr", 32'(imem_addr), 32'd0);
    chk("post_rst_discard", 32'(discard_cnt), 32'd0);

    // Random traffic.
    gnt_pct = 70;
    lat_min = 1;
    lat_max = 3;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst         = ($urandom_range(399) != 0);
      pause       = ($urandom_range(2) == 0);
      redirect    = ($urandom_range(9) == 0);
      redirect_pc = 9'($urandom);
    end

    // Redirect-heavy traffic to drive the discard counter into saturation.
    rst     = 1'b1;
    gnt_pct = 100;
    lat_max = 2;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      pause       = ($urandom_range(1) == 0);
      redirect    = ($urandom_range(9) != 0);
      redirect_pc = 9'($urandom);
    end
    redirect = 1'b0;
    pause    = 1'b0;
    repeat (3) @(negedge clk);
    chk("discard_saturated", 32'(discard_cnt), 32'd255);

    repeat (20) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
